// File: rtl/lbp_scan_ctrl.sv
// Scan sequencer for the LBP engine: raster-walks interior centres, fetches 3x3 windows with column reuse.
// Optional macro BORDER_WRITE_EN adds a pass that clears every border result address before finish.
module lbp_scan_ctrl #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gray_ready,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    output logic              win_load,
    output logic [3:0]        win_idx,
    output logic              win_shift,
    output logic              calc_en,
    output logic              lbp_valid,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic              lbp_clr,
    output logic              finish
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = ADDR_W - COL_W;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 2);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 2);
`ifdef BORDER_WRITE_EN
    localparam logic [COL_W-1:0] EDGE_COL = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] EDGE_ROW = ROW_W'(IMG_H - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH9 = 3'd1,
        S_FETCH3 = 3'd2,
        S_DRAIN  = 3'd3,
        S_CALC   = 3'd4,
        S_WRITE  = 3'd5,
`ifdef BORDER_WRITE_EN
        S_BORDER = 3'd6,
`endif
        S_DONE   = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [3:0]         slot_q, slot_d;
    logic               win_load_q;
    logic [3:0]         win_idx_q;
    logic               gray_req_s;
    logic [ROW_W-1:0]   rd_row_s;
    logic [COL_W-1:0]   rd_col_s;
    logic               win_shift_s;
    logic               calc_en_s;
    logic               lbp_valid_s;
    logic [ADDR_W-1:0]  lbp_addr_s;
`ifdef BORDER_WRITE_EN
    logic               lbp_clr_s;
`endif

    // Window slot -> row offset (0..2) relative to r-1
    function automatic logic [1:0] slot_row(input logic [3:0] slot);
        case (slot)
            4'd0, 4'd1, 4'd2: slot_row = 2'd0;
            4'd3, 4'd4, 4'd5: slot_row = 2'd1;
            4'd6, 4'd7, 4'd8: slot_row = 2'd2;
            default:          slot_row = 2'd0;
        endcase
    endfunction

    // Window slot -> column offset (0..2) relative to c-1
    function automatic logic [1:0] slot_col(input logic [3:0] slot);
        case (slot)
            4'd0, 4'd3, 4'd6: slot_col = 2'd0;
            4'd1, 4'd4, 4'd7: slot_col = 2'd1;
            4'd2, 4'd5, 4'd8: slot_col = 2'd2;
            default:          slot_col = 2'd0;
        endcase
    endfunction

    // Next-state, scan position and strobe decode
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        slot_d      = slot_q;
        gray_req_s  = 1'b0;
        win_shift_s = 1'b0;
        calc_en_s   = 1'b0;
        lbp_valid_s = 1'b0;
        lbp_addr_s  = {ADDR_W{1'b0}};
`ifdef BORDER_WRITE_EN
        lbp_clr_s   = 1'b0;
`endif
        rd_row_s    = row_q + ROW_W'(slot_row(slot_q)) - ROW_W'(1);
        rd_col_s    = col_q + COL_W'(slot_col(slot_q)) - COL_W'(1);
        case (state_q)
            S_IDLE: begin
                if (gray_ready) begin
                    state_d = S_FETCH9;
                    slot_d  = 4'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH9, S_FETCH3: begin
                if (gray_ready) begin
                    gray_req_s = 1'b1;
                    if (slot_q == 4'd8) begin
                        state_d = S_DRAIN;
                    end else if (state_q == S_FETCH9) begin
                        slot_d = slot_q + 4'd1;
                    end else begin
                        // column reuse: only the right-hand column (2,5,8) is fetched
                        slot_d = slot_q + 4'd3;
                    end
                end else begin
                    slot_d = slot_q;
                end
            end
            S_DRAIN: begin
                state_d = S_CALC;
            end
            S_CALC: begin
                calc_en_s = 1'b1;
                state_d   = S_WRITE;
            end
            S_WRITE: begin
                lbp_valid_s = 1'b1;
                lbp_addr_s  = {row_q, col_q};
                if (col_q < LAST_COL) begin
                    win_shift_s = 1'b1;
                    col_d       = col_q + COL_W'(1);
                    slot_d      = 4'd2;
                    state_d     = S_FETCH3;
                end else if (row_q < LAST_ROW) begin
                    col_d   = COL_W'(1);
                    row_d   = row_q + ROW_W'(1);
                    slot_d  = 4'd0;
                    state_d = S_FETCH9;
                end else begin
`ifdef BORDER_WRITE_EN
                    row_d   = ROW_W'(0);
                    col_d   = COL_W'(0);
                    state_d = S_BORDER;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef BORDER_WRITE_EN
            S_BORDER: begin
                lbp_valid_s = 1'b1;
                lbp_clr_s   = 1'b1;
                lbp_addr_s  = {row_q, col_q};
                // top/bottom rows sweep every column; middle rows touch only col 0 and the last col
                if ((row_q == ROW_W'(0)) || (row_q == EDGE_ROW)) begin
                    if (col_q == EDGE_COL) begin
                        if (row_q == EDGE_ROW) begin
                            state_d = S_DONE;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                            col_d = COL_W'(0);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end else if (col_q == COL_W'(0)) begin
                    col_d = EDGE_COL;
                end else begin
                    row_d = row_q + ROW_W'(1);
                    col_d = COL_W'(0);
                end
            end
`endif
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, scan position and 1-cycle read-return tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            row_q      <= ROW_W'(1);
            col_q      <= COL_W'(1);
            slot_q     <= 4'd0;
            win_load_q <= 1'b0;
            win_idx_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            slot_q     <= slot_d;
            win_load_q <= gray_req_s;
            win_idx_q  <= gray_req_s ? slot_q : 4'd0;
        end
    end

    assign gray_req  = gray_req_s;
    assign gray_addr = gray_req_s ? {rd_row_s, rd_col_s} : {ADDR_W{1'b0}};
    assign win_load  = win_load_q;
    assign win_idx   = win_idx_q;
    assign win_shift = win_shift_s;
    assign calc_en   = calc_en_s;
    assign lbp_valid = lbp_valid_s;
    assign lbp_addr  = lbp_addr_s;
    assign finish    = (state_q == S_DONE);
`ifdef BORDER_WRITE_EN
    assign lbp_clr   = lbp_clr_s;
`else
    assign lbp_clr   = 1'b0;
`endif

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Scoreboard bench: a 128x128 instance for address/timing/stall/reset behaviour, a 16x8 instance for a full scan to finish.
module tb_lbp_scan_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 128x128 instance
    logic a_reset, a_ready, a_gray_req, a_win_load, a_win_shift, a_calc_en, a_lbp_valid, a_lbp_clr, a_finish;
    logic [13:0] a_gray_addr, a_lbp_addr;
    logic [3:0]  a_win_idx;
    lbp_scan_ctrl u_a (
        .clk(clk), .reset(a_reset), .gray_ready(a_ready), .gray_req(a_gray_req), .gray_addr(a_gray_addr),
        .win_load(a_win_load), .win_idx(a_win_idx), .win_shift(a_win_shift), .calc_en(a_calc_en),
        .lbp_valid(a_lbp_valid), .lbp_addr(a_lbp_addr), .lbp_clr(a_lbp_clr), .finish(a_finish));

    // 16x8 instance
    logic b_reset, b_ready, b_gray_req, b_win_load, b_win_shift, b_calc_en, b_lbp_valid, b_lbp_clr, b_finish;
    logic [6:0] b_gray_addr, b_lbp_addr;
    logic [3:0] b_win_idx;
    lbp_scan_ctrl #(.IMG_W(16), .IMG_H(8), .ADDR_W(7)) u_b (
        .clk(clk), .reset(b_reset), .gray_ready(b_ready), .gray_req(b_gray_req), .gray_addr(b_gray_addr),
        .win_load(b_win_load), .win_idx(b_win_idx), .win_shift(b_win_shift), .calc_en(b_calc_en),
        .lbp_valid(b_lbp_valid), .lbp_addr(b_lbp_addr), .lbp_clr(b_lbp_clr), .finish(b_finish));

`ifdef BORDER_WRITE_EN
    localparam int B_BORDER = 44;
`else
    localparam int B_BORDER = 0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboards
    int exp_req[$];
    int exp_slot[$];
    int exp_wr[$];
    int exp_b_wr[$];
    bit exp_b_clr[$];

    // Expected request/write order of the 128-wide scan for rows 1..nrows
    task automatic push_a(input int nrows);
        for (int r = 1; r <= nrows; r++) begin
            for (int c = 1; c <= 126; c++) begin
                if (c == 1) begin
                    for (int s = 0; s < 9; s++) begin
                        exp_req.push_back((r - 1 + s / 3) * 128 + (c - 1 + s % 3));
                        exp_slot.push_back(s);
                    end
                end else begin
                    for (int dr = 0; dr < 3; dr++) begin
                        exp_req.push_back((r - 1 + dr) * 128 + c + 1);
                        exp_slot.push_back(3 * dr + 2);
                    end
                end
                exp_wr.push_back(r * 128 + c);
            end
        end
    endtask

    task automatic push_b();
        for (int r = 1; r <= 6; r++)
            for (int c = 1; c <= 14; c++) begin
                exp_b_wr.push_back(r * 16 + c);
                exp_b_clr.push_back(1'b0);
            end
`ifdef BORDER_WRITE_EN
        for (int c = 0; c < 16; c++) begin exp_b_wr.push_back(c); exp_b_clr.push_back(1'b1); end
        for (int r = 1; r <= 6; r++) begin
            exp_b_wr.push_back(r * 16);      exp_b_clr.push_back(1'b1);
            exp_b_wr.push_back(r * 16 + 15); exp_b_clr.push_back(1'b1);
        end
        for (int c = 0; c < 16; c++) begin exp_b_wr.push_back(112 + c); exp_b_clr.push_back(1'b1); end
`endif
    endtask

    // Monitor for the 128x128 instance
    int a_req_cnt = 0, a_wr_cnt = 0, a_first_req_cyc = -1, a_pend_slot = -1;
    int a_wr_cyc[$];
    bit a_prev_calc = 1'b0;
    always @(negedge clk) begin
        if (a_reset) begin
            a_pend_slot = -1;
            a_prev_calc = 1'b0;
        end else begin
            if (a_pend_slot >= 0) begin
                chk("a_win_load", a_win_load, 1);
                chk("a_win_idx", a_win_idx, a_pend_slot);
            end else begin
                chk("a_win_load_idle", a_win_load, 0);
            end
            a_pend_slot = -1;
            chk("a_shift_only_on_write", a_win_shift & ~a_lbp_valid, 0);
            if (a_gray_req) begin
                if (exp_req.size() == 0) begin
                    chk("a_unexpected_req", a_gray_addr, -1);
                end else begin
                    chk("a_gray_addr", a_gray_addr, exp_req.pop_front());
                    a_pend_slot = exp_slot.pop_front();
                end
                chk("a_req_exclusive", a_lbp_valid | a_calc_en | a_win_shift, 0);
                if (a_first_req_cyc < 0) a_first_req_cyc = cyc;
                a_req_cnt++;
            end
            if (a_lbp_valid) begin
                if (exp_wr.size() == 0) begin
                    chk("a_unexpected_write", a_lbp_addr, -1);
                end else begin
                    int e;
                    e = exp_wr.pop_front();
                    chk("a_lbp_addr", a_lbp_addr, e);
                    chk("a_win_shift", a_win_shift, (e % 128) != 126);
                end
                chk("a_calc_before_write", a_prev_calc, 1);
                chk("a_calc_with_write", a_calc_en, 0);
                chk("a_lbp_clr", a_lbp_clr, 0);
                a_wr_cyc.push_back(cyc);
                a_wr_cnt++;
            end
            a_prev_calc = a_calc_en;
        end
    end

    // Monitor for the 16x8 instance
    int b_req_cnt = 0, b_wr_cnt = 0, b_first_req_cyc = -1, b_last_wr_cyc = -1, b_last_int_cyc = -1, b_fin_cyc = -1;
    always @(negedge clk) begin
        if (!b_reset) begin
            if (b_gray_req) begin
                if (b_first_req_cyc < 0) b_first_req_cyc = cyc;
                b_req_cnt++;
            end
            if (b_lbp_valid) begin
                if (exp_b_wr.size() == 0) begin
                    chk("b_unexpected_write", b_lbp_addr, -1);
                end else begin
                    chk("b_lbp_addr", b_lbp_addr, exp_b_wr.pop_front());
                    chk("b_lbp_clr", b_lbp_clr, exp_b_clr.pop_front());
                end
                b_wr_cnt++;
                b_last_wr_cyc = cyc;
                if (!b_lbp_clr) b_last_int_cyc = cyc;
            end
            if (b_finish && b_fin_cyc < 0) b_fin_cyc = cyc;
        end
    end

    task automatic check_a_zero(input string name);
        chk(name, {a_gray_req, a_gray_addr, a_win_load, a_win_idx, a_win_shift, a_calc_en,
                   a_lbp_valid, a_lbp_addr, a_lbp_clr, a_finish}, 0);
    endtask

    task automatic run_a();
        int guard;
        // first scan, gray_ready held high
        @(posedge clk); #1 a_ready = 1'b1;
        guard = 0;
        while (a_wr_cnt < 128 && guard < 2000) begin @(posedge clk); guard++; end
        chk("a_run1_timeout", guard < 2000, 1);
        if (a_wr_cyc.size() >= 127) begin
            chk("a_first_write_latency", a_wr_cyc[0] - a_first_req_cyc, 11);
            chk("a_second_write_gap", a_wr_cyc[1] - a_wr_cyc[0], 6);
            chk("a_row_change_gap", a_wr_cyc[126] - a_wr_cyc[125], 12);
        end
        // asynchronous reset mid-row
        repeat (2) @(posedge clk);
        #2 a_reset = 1'b1;
        #1 check_a_zero("a_async_reset_outputs");
        repeat (2) @(posedge clk);
        exp_req.delete(); exp_slot.delete(); exp_wr.delete(); a_wr_cyc.delete();
        a_req_cnt = 0; a_wr_cnt = 0; a_first_req_cyc = -1;
        push_a(1);
        a_ready = 1'b0;
        @(negedge clk) a_reset = 1'b0;
        repeat (3) begin @(negedge clk); chk("a_idle_no_req", a_gray_req, 0); end
        @(posedge clk); #1 a_ready = 1'b1;
        guard = 0;
        while (a_req_cnt < 4 && guard < 100) begin @(posedge clk); guard++; end
        chk("a_req4_timeout", guard < 100, 1);
        #1 a_ready = 1'b0;
        repeat (5) begin @(negedge clk); chk("a_stall_no_req", a_gray_req, 0); end
        @(posedge clk); #1 a_ready = 1'b1;
        guard = 0;
        while (a_wr_cnt < 3 && guard < 200) begin @(posedge clk); guard++; end
        chk("a_run2_timeout", guard < 200, 1);
        if (a_wr_cyc.size() >= 2) begin
            chk("a_stalled_first_latency", a_wr_cyc[0] - a_first_req_cyc, 16);
            chk("a_after_stall_gap", a_wr_cyc[1] - a_wr_cyc[0], 6);
        end
    endtask

    task automatic run_b();
        int guard;
        guard = 0;
        while (b_fin_cyc < 0 && guard < 3000) begin @(posedge clk); guard++; end
        chk("b_finish_timeout", guard < 3000, 1);
        chk("b_write_count", b_wr_cnt, 84 + B_BORDER);
        chk("b_req_count", b_req_cnt, 288);
        chk("b_writes_left", exp_b_wr.size(), 0);
        chk("b_finish_after_last_write", b_fin_cyc - b_last_wr_cyc, 1);
        chk("b_scan_cycles", b_last_int_cyc - b_first_req_cyc, 539);
        repeat (5) @(posedge clk);
        #1 chk("b_finish_held", b_finish, 1);
        chk("b_no_req_after_finish", b_req_cnt, 288);
    endtask

    initial begin
        a_reset = 1'b1; b_reset = 1'b1; a_ready = 1'b0; b_ready = 1'b0;
        push_a(3);
        push_b();
        repeat (3) @(posedge clk);
        #1 check_a_zero("a_reset_outputs");
        chk("b_reset_outputs", {b_gray_req, b_gray_addr, b_win_load, b_win_idx, b_win_shift, b_calc_en,
                                b_lbp_valid, b_lbp_addr, b_lbp_clr, b_finish}, 0);
        @(negedge clk);
        a_reset = 1'b0; b_reset = 1'b0; b_ready = 1'b1;
        repeat (3) begin @(negedge clk); chk("a_idle_no_req_initial", a_gray_req, 0); end
        fork
            run_a();
            run_b();
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got running expected done");
        $fatal(1, "watchdog");
    end
endmodule
